// File: rtl/reg_select_sequencer.sv
// Register select/encode stage for the Mini-SRC register file: decodes IR fields into one-hot
// Rin/Rout strobes and can sweep a strobe across registers. Optional: REG_SEL_SWEEP_DOWN_EN.
module reg_select_sequencer #(
  parameter int SEL_W  = 4,
  parameter int N_REG  = 2**SEL_W,
  parameter int IR_W   = 32,
  parameter int RA_LSB = 23,
  parameter int RB_LSB = 19,
  parameter int RC_LSB = 15
) (
  input  logic             clk,
  input  logic             clr,
  input  logic [IR_W-1:0]  ir,
  input  logic             gra,
  input  logic             grb,
  input  logic             grc,
  input  logic             rin,
  input  logic             rout,
  input  logic             ba_out,
  input  logic             sweep_start,
  input  logic [SEL_W-1:0] sweep_base,
  input  logic [SEL_W:0]   sweep_cnt,
  input  logic             sweep_wr,
  input  logic             sweep_abort,
`ifdef REG_SEL_SWEEP_DOWN_EN
  input  logic             sweep_down,
`endif
  output logic [N_REG-1:0] r_in,
  output logic [N_REG-1:0] r_out,
  output logic             busy,
  output logic             done
);

  localparam int               CNT_W    = SEL_W + 1;
  localparam logic [SEL_W:0]   CNT_MAX  = CNT_W'(N_REG);
  localparam logic [SEL_W-1:0] LAST_IDX = SEL_W'(N_REG - 1);

  typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

  state_t           state;
  logic [SEL_W-1:0] cur_idx;
  logic [SEL_W:0]   remain;
  logic             wr_mode;
  logic             dir_down;

  logic [SEL_W-1:0] idx;
  logic [SEL_W-1:0] nxt_idx;
  logic [SEL_W:0]   start_cnt;
  logic [N_REG-1:0] dec_in;
  logic [N_REG-1:0] dec_out;
  logic             sel_valid;
  logic             start_down;
  logic             unused_ir;

  // Only the three register fields are decoded; the rest of the IR belongs to other stages.
  assign unused_ir = ^ir;

  function automatic logic [N_REG-1:0] onehot(input logic [SEL_W-1:0] i);
    logic [N_REG-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

`ifdef REG_SEL_SWEEP_DOWN_EN
  assign start_down = sweep_down;
`else
  assign start_down = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    sel_valid = gra | grb | grc;
    idx       = ir[RC_LSB +: SEL_W];
    if (gra)      idx = ir[RA_LSB +: SEL_W];
    else if (grb) idx = ir[RB_LSB +: SEL_W];
    dec_in    = (sel_valid && rin) ? onehot(idx) : '0;
    // Base-address reads of R0 return the constant zero, so no register is enabled.
    dec_out   = (sel_valid && (rout || (ba_out && idx != '0))) ? onehot(idx) : '0;
    start_cnt = (sweep_cnt > CNT_MAX) ? CNT_MAX : sweep_cnt;
    nxt_idx   = (cur_idx == LAST_IDX) ? '0 : cur_idx + 1'b1;
    if (dir_down) nxt_idx = (cur_idx == '0) ? LAST_IDX : cur_idx - 1'b1;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge clr) begin
    if (clr) begin
      state    <= IDLE;
      cur_idx  <= '0;
      remain   <= '0;
      wr_mode  <= 1'b0;
      dir_down <= 1'b0;
      r_in     <= '0;
      r_out    <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (sweep_start) begin
            if (start_cnt == '0) begin
              r_in  <= '0;
              r_out <= '0;
              done  <= 1'b1;
              state <= DONE;
            end else begin
              // The first strobe is issued on the start edge; remain counts the strobes still owed.
              cur_idx  <= sweep_base;
              remain   <= start_cnt - 1'b1;
              wr_mode  <= sweep_wr;
              dir_down <= start_down;
              r_in     <= sweep_wr ? onehot(sweep_base) : '0;
              r_out    <= sweep_wr ? '0 : onehot(sweep_base);
              busy     <= 1'b1;
              state    <= SWEEP;
            end
          end else begin
            r_in  <= dec_in;
            r_out <= dec_out;
          end
        end
        SWEEP: begin
          if (sweep_abort) begin
            r_in  <= '0;
            r_out <= '0;
            busy  <= 1'b0;
            state <= IDLE;
          end else if (remain == '0) begin
            r_in  <= '0;
            r_out <= '0;
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= DONE;
          end else begin
            cur_idx <= nxt_idx;
            remain  <= remain - 1'b1;
            r_in    <= wr_mode ? onehot(nxt_idx) : '0;
            r_out   <= wr_mode ? '0 : onehot(nxt_idx);
          end
        end
        default: begin
          r_in  <= '0;
          r_out <= '0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg_select_sequencer.sv
// Self-checking bench for reg_select_sequencer: directed cases plus randomized decode and sweep
// traffic checked against an arithmetic reference model.
module tb_reg_select_sequencer;

  logic        clk = 1'b0;
  logic        clr;
  logic [31:0] ir;
  logic        gra, grb, grc, rin, rout, ba_out;
  logic        sweep_start, sweep_wr, sweep_abort;
  logic [3:0]  sweep_base;
  logic [4:0]  sweep_cnt;
`ifdef REG_SEL_SWEEP_DOWN_EN
  logic        sweep_down;
`endif
  logic [15:0] r_in, r_out;
  logic        busy, done;

  int checks   = 0;
  int failures = 0;

  reg_select_sequencer dut (
    .clk         (clk),
    .clr         (clr),
    .ir          (ir),
    .gra         (gra),
    .grb         (grb),
    .grc         (grc),
    .rin         (rin),
    .rout        (rout),
    .ba_out      (ba_out),
    .sweep_start (sweep_start),
    .sweep_base  (sweep_base),
    .sweep_cnt   (sweep_cnt),
    .sweep_wr    (sweep_wr),
    .sweep_abort (sweep_abort),
`ifdef REG_SEL_SWEEP_DOWN_EN
    .sweep_down  (sweep_down),
`endif
    .r_in        (r_in),
    .r_out       (r_out),
    .busy        (busy),
    .done        (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s obs=%h exp=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    ir = '0; gra = 0; grb = 0; grc = 0; rin = 0; rout = 0; ba_out = 0;
    sweep_start = 0; sweep_base = '0; sweep_cnt = '0; sweep_wr = 0; sweep_abort = 0;
`ifdef REG_SEL_SWEEP_DOWN_EN
    sweep_down = 0;
`endif
  endtask

  task automatic check_all(input string tag, input logic [15:0] ei, input logic [15:0] eo,
                           input logic eb, input logic ed);
    check({tag, ".r_in"},  {16'h0, r_in},  {16'h0, ei});
    check({tag, ".r_out"}, {16'h0, r_out}, {16'h0, eo});
    check({tag, ".busy"},  {31'h0, busy},  {31'h0, eb});
    check({tag, ".done"},  {31'h0, done},  {31'h0, ed});
  endtask

  function automatic logic [31:0] make_ir(input int ra, input int rb, input int rc);
    return (ra << 23) | (rb << 19) | (rc << 15) | ($urandom & 32'h7FFF) | ($urandom << 27);
  endfunction

  // Reference decode: pick the field by priority, one-hot it, apply the strobe requests.
  task automatic decode_op(input string tag, input logic [31:0] iv, input logic a, input logic b,
                           input logic c, input logic ri, input logic ro, input logic ba);
    int idx;
    logic [15:0] ei, eo;
    idle_inputs();
    ir = iv; gra = a; grb = b; grc = c; rin = ri; rout = ro; ba_out = ba;
    step();
    if (a)      idx = (iv >> 23) % 16;
    else if (b) idx = (iv >> 19) % 16;
    else        idx = (iv >> 15) % 16;
    ei = ((a || b || c) && ri) ? 16'(1 << idx) : 16'h0;
    eo = ((a || b || c) && (ro || (ba && idx != 0))) ? 16'(1 << idx) : 16'h0;
    check_all(tag, ei, eo, 1'b0, 1'b0);
  endtask

  // Reference sweep: strobe k sits at (base +/- k) mod 16, for min(cnt,16) cycles, then one done.
  task automatic run_sweep(input string tag, input int base, input int cnt, input logic wr,
                           input logic down);
    int n, idx;
    logic [15:0] v;
    idle_inputs();
    sweep_start = 1; sweep_base = 4'(base); sweep_cnt = 5'(cnt); sweep_wr = wr;
`ifdef REG_SEL_SWEEP_DOWN_EN
    sweep_down = down;
`endif
    step();
    sweep_start = 0;
    n = (cnt > 16) ? 16 : cnt;
    for (int k = 0; k < n; k++) begin
`ifdef REG_SEL_SWEEP_DOWN_EN
      idx = down ? (((base - k) % 16) + 16) % 16 : (base + k) % 16;
`else
      idx = (base + k) % 16;
`endif
      v = 16'(1 << idx);
      check_all($sformatf("%s.s%0d", tag, k), wr ? v : 16'h0, wr ? 16'h0 : v, 1'b1, 1'b0);
      step();
    end
    check_all({tag, ".done"}, 16'h0, 16'h0, 1'b0, 1'b1);
    step();
    check_all({tag, ".after"}, 16'h0, 16'h0, 1'b0, 1'b0);
  endtask

  initial begin
    idle_inputs();
    clr = 1;
    #1;
    check_all("rst_init", 16'h0, 16'h0, 1'b0, 1'b0);
    step();
    clr = 0;
    step();

    // Reset mid-sweep must clear outputs immediately, without a clock edge.
    sweep_start = 1; sweep_base = 4'd3; sweep_cnt = 5'd8; sweep_wr = 1;
    step();
    sweep_start = 0;
    check("rst_sweep_pre", {16'h0, r_in}, 32'h0008);
    #2 clr = 1;
    #1;
    check_all("rst_async", 16'h0, 16'h0, 1'b0, 1'b0);
    step();
    clr = 0;
    idle_inputs();
    step(); step();
    check_all("rst_after", 16'h0, 16'h0, 1'b0, 1'b0);

    // Directed decode cases.
    idle_inputs();
    ir = (5 << 23) | (9 << 19); gra = 1; grb = 1; rin = 1;
    step();
    check_all("dec_ra", 16'h0020, 16'h0000, 1'b0, 1'b0);
    idle_inputs();
    ir = (15 << 15); grc = 1; rout = 1;
    step();
    check_all("dec_rc", 16'h0000, 16'h8000, 1'b0, 1'b0);
    idle_inputs();
    ir = (0 << 19); grb = 1; ba_out = 1;
    step();
    check("ba_r0", {16'h0, r_out}, 32'h0);
    ir = (2 << 19);
    step();
    check("ba_r2", {16'h0, r_out}, 32'h0004);
    ir = (0 << 19); rout = 1;
    step();
    check("ba_r0_rout", {16'h0, r_out}, 32'h0001);
    idle_inputs();
    ir = (7 << 23); rin = 1; rout = 1;
    step();
    check_all("dec_nogr", 16'h0, 16'h0, 1'b0, 1'b0);

    // Directed sweeps: wrap-around, zero count, over-range count.
    run_sweep("wrap", 14, 4, 1'b1, 1'b0);
    run_sweep("cnt0", 6, 0, 1'b1, 1'b0);
    run_sweep("cnt20", 9, 20, 1'b0, 1'b0);
`ifdef REG_SEL_SWEEP_DOWN_EN
    run_sweep("down", 1, 4, 1'b1, 1'b1);
`endif

    // Contention while busy, then abort during the second strobe.
    idle_inputs();
    sweep_start = 1; sweep_base = 4'd5; sweep_cnt = 5'd6; sweep_wr = 0;
    step();
    check_all("ab.s0", 16'h0, 16'h0020, 1'b1, 1'b0);
    sweep_start = 1; sweep_base = 4'd0; sweep_wr = 1;
    ir = (1 << 23); gra = 1; rin = 1; rout = 1;
    step();
    check_all("ab.s1", 16'h0, 16'h0040, 1'b1, 1'b0);
    idle_inputs();
    sweep_abort = 1;
    step();
    check_all("ab.idle", 16'h0, 16'h0, 1'b0, 1'b0);
    sweep_abort = 0;
    step();
    check_all("ab.nodone", 16'h0, 16'h0, 1'b0, 1'b0);
    sweep_abort = 1;
    step();
    check_all("ab.ignored", 16'h0, 16'h0, 1'b0, 1'b0);

    // Randomized decode traffic.
    for (int i = 0; i < 40; i++) begin
      int ra, rb, rc;
      ra = $urandom_range(0, 15);
      rb = ($urandom_range(0, 3) == 0) ? 0 : $urandom_range(0, 15);
      rc = $urandom_range(0, 15);
      decode_op($sformatf("rnd_dec%0d", i), make_ir(ra, rb, rc), 1'($urandom), 1'($urandom),
                1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    // Randomized sweeps.
    for (int i = 0; i < 8; i++) begin
      run_sweep($sformatf("rnd_sw%0d", i), $urandom_range(0, 15), $urandom_range(0, 20),
                1'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/reg_select_sequencer.md
Name: reg_select_sequencer

Overview:
Parametrised successor to the plain 4-to-16 enable decoder. It is the select-and-encode stage for the Mini-SRC register file.
- Extracts Ra/Rb/Rc fields from the IR and produces registered one-hot Rin/Rout strobes.
- Adds an autonomous sweep mode that walks a one-hot strobe across consecutive registers, for multi-register load/store and debug dump.
- Sits between the control unit and the register bank.

Parameters:
- SEL_W, 4, register-index width.
- N_REG, 2**SEL_W, number of registers / one-hot width.
- IR_W, 32, instruction register width.
- RA_LSB, 23, LSB of Ra field in IR.
- RB_LSB, 19, LSB of Rb field in IR.
- RC_LSB, 15, LSB of Rc field in IR.

Ports:
- clk  in  1  system clock, rising edge.
- clr  in  1  asynchronous active-high reset.
- ir  in  IR_W  instruction register contents.
- gra  in  1  select Ra field.
- grb  in  1  select Rb field.
- grc  in  1  select Rc field.
- rin  in  1  request write strobe.
- rout  in  1  request read strobe.
- ba_out  in  1  base-address read; R0 yields no strobe.
- sweep_start  in  1  start sweep (single-cycle pulse).
- sweep_base  in  SEL_W  first register index of sweep.
- sweep_cnt  in  SEL_W+1  number of registers to sweep.
- sweep_wr  in  1  1 = drive r_in during sweep, 0 = drive r_out.
- sweep_abort  in  1  terminate sweep.
- r_in  out  N_REG  one-hot register write enables.
- r_out  out  N_REG  one-hot register read enables.
- busy  out  1  sweep in progress.
- done  out  1  single-cycle sweep-complete pulse.

Behaviour:
- Clock/reset: one clock. Reset is asynchronous and active-high: clr forces r_in=0, r_out=0, busy=0, done=0, state IDLE and the internal index to 0 immediately, independent of clk. A reset mid-sweep abandons the sweep with no done pulse.
- FSM states: IDLE, SWEEP, DONE.
- IDLE, decode path (registered, 1-cycle latency):
  - idx = Ra if gra; else Rb if grb; else Rc if grc. Priority is gra > grb > grc.
  - No gr asserted: r_in=0 and r_out=0 next cycle.
  - r_in <= rin ? onehot(idx) : 0.
  - r_out <= (rout | (ba_out & idx!=0)) ? onehot(idx) : 0.
  - ba_out with idx==0 and rout=0: r_out=0.
  - rin and rout together is legal; both vectors are driven.
- IDLE + sweep_start:
  - sweep_start takes priority over the decode path in the same cycle; decode outputs go to 0.
  - cnt = min(sweep_cnt, N_REG).
  - cnt==0: go to DONE directly; no strobes.
  - cnt>0: latch base, cnt and sweep_wr, then go to SWEEP.
- SWEEP:
  - busy=1.
  - Each cycle one bit is asserted at cur_idx, on r_in if the latched wr=1, else on r_out. The other vector is 0.
  - First strobe appears the cycle after sweep_start.
  - cur_idx increments modulo N_REG, so it wraps from N_REG-1 to 0.
  - After cnt strobes: go to DONE; busy drops with the last strobe.
- DONE: done=1 for exactly one cycle, all strobes 0, then IDLE.
- While busy:
  - gr*/rin/rout/ba_out are ignored.
  - sweep_start is ignored.
  - sweep_abort returns the FSM to IDLE next cycle: strobes 0, busy=0, no done.
  - sweep_abort is ignored in IDLE and DONE.
- Invariant: r_in and r_out are each at most one-hot at every cycle.

Optional Feature:
- Macro: REG_SEL_SWEEP_DOWN_EN.
- When defined: adds input port sweep_down (1 bit), latched at sweep_start. When 1, cur_idx decrements modulo N_REG (wraps 0 to N_REG-1).
- When undefined: the port is absent and the sweep is ascending only.

Test Plan:
- Reset: clr=1 mid-sweep at base 3 -> r_in, r_out, busy, done all 0 immediately. After release, outputs stay 0 with idle inputs.
- Decode: ir Ra=5, Rb=9, gra=1, grb=1, rin=1 -> next cycle r_in=16'h0020, r_out=0. Then grc=1 only, Rc=15, rout=1 -> r_out=16'h8000.
- BA: grb=1, Rb=0, ba_out=1 -> r_out=0. Same with Rb=2 -> r_out=16'h0004. With rout=1 and Rb=0 -> r_out=16'h0001.
- Wrap sweep: sweep_base=14, sweep_cnt=4, sweep_wr=1 -> r_in=4000, 8000, 0001, 0002 on consecutive cycles, busy=1 for those 4 cycles, then done=1 for one cycle.
- Edge counts: sweep_cnt=0 -> done pulse next cycle, no strobes. sweep_cnt=20 -> exactly 16 strobes.
- Abort/contention: sweep_abort during the 2nd strobe -> IDLE next cycle, no done. A decode request or sweep_start issued while busy produces no extra strobes.
